// File: rtl/pipe_stage_buf_pkg.sv
// ============================================================================
// Module      : pipe_stage_buf_pkg
// Description : Shared stage identifiers, payload widths and ID/EX field map
//               for the generic pipeline-stage buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        STG_IFID  = 2'd0,
        STG_IDEX  = 2'd1,
        STG_EXMEM = 2'd2,
        STG_MEMWB = 2'd3
    } pipe_stage_e;

    localparam int c_IFID_DATA_W  = 64;
    localparam int c_IDEX_DATA_W  = 256;
    localparam int c_EXMEM_DATA_W = 160;
    localparam int c_MEMWB_DATA_W = 104;

    // ID/EX payload layout, LSB first
    localparam int c_IDEX_PC_LSB   = 0;
    localparam int c_IDEX_PC_W     = 32;
    localparam int c_IDEX_OPA_LSB  = 32;
    localparam int c_IDEX_OPA_W    = 32;
    localparam int c_IDEX_OPB_LSB  = 64;
    localparam int c_IDEX_OPB_W    = 32;
    localparam int c_IDEX_IMM_LSB  = 96;
    localparam int c_IDEX_IMM_W    = 32;
    localparam int c_IDEX_CTRL_LSB = 128;
    localparam int c_IDEX_CTRL_W   = 96;
    localparam int c_IDEX_EXC_LSB  = 224;
    localparam int c_IDEX_EXC_W    = 32;

    localparam logic [c_IDEX_DATA_W-1:0] c_IDEX_NOP_VAL = '0;

    function automatic int stage_data_w(input pipe_stage_e stg);
        case (stg)
            STG_IFID:  return c_IFID_DATA_W;
            STG_IDEX:  return c_IDEX_DATA_W;
            STG_EXMEM: return c_EXMEM_DATA_W;
            default:   return c_MEMWB_DATA_W;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_buf_entry.sv
// ============================================================================
// Module      : pipe_entry
// Description : One payload register plus valid bit with clear/load control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_entry #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Clear outranks load so a squash can never be overridden by a refill
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module      : pipe_stage_buf
// Description : Generic handshaked pipeline-stage register with optional skid
//               entry, deferred flush under stall and saturating bubble count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W    = c_IDEX_DATA_W,
    parameter logic [DATA_W-1:0] NOP_VAL   = '0,
    parameter int                SKID_EN   = 1,
    parameter int                BUB_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_nop,
    input  logic                 cu_stall,
    input  logic                 cu_flush,
    output logic                 flush_pend,
    output logic [1:0]           occupancy,
    output logic [BUB_CNT_W-1:0] bubble_cnt,
    input  logic                 bubble_clr
);

    logic                 w_m_valid, w_s_valid;
    logic [DATA_W-1:0]    w_m_data,  w_s_data;
    logic                 w_m_load,  w_m_clear, w_s_load, w_s_clear;
    logic [DATA_W-1:0]    w_m_d;
    logic                 w_flush, w_issue, w_accept, w_in_ready;
    logic                 r_rdy_en, r_flush_pend;
    logic [BUB_CNT_W-1:0] r_bub_cnt;

    // A flush held back by a stall fires on the first unstalled edge
    assign w_flush  = !cu_stall && (cu_flush || r_flush_pend);
    assign w_issue  = w_m_valid && out_ready && !cu_stall;
    assign w_accept = in_valid && w_in_ready;

    always_comb begin
        w_m_load  = 1'b0;
        w_m_clear = 1'b0;
        w_s_load  = 1'b0;
        w_s_clear = 1'b0;
        w_m_d     = in_data;
        if (w_flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else if (!cu_stall) begin
            if (w_issue) begin
                if (w_s_valid) begin
                    w_m_load  = 1'b1;
                    w_m_d     = w_s_data;
                    w_s_clear = 1'b1;
                end else if (w_accept) begin
                    w_m_load  = 1'b1;
                end else begin
                    w_m_clear = 1'b1;
                end
            end else if (w_accept) begin
                if (w_m_valid) w_s_load = 1'b1;
                else           w_m_load = 1'b1;
            end
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_d),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_s_load),
                .i_clear (w_s_clear),
                .i_data  (in_data),
                .o_valid (w_s_valid),
                .o_data  (w_s_data)
            );
            assign w_in_ready = r_rdy_en && !w_s_valid && !cu_stall;
        end else begin : g_no_skid
            assign w_s_valid  = 1'b0;
            assign w_s_data   = NOP_VAL;
            assign w_in_ready = r_rdy_en && (!w_m_valid || out_ready) && !cu_stall;
        end
    endgenerate

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy_en     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_bub_cnt    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (cu_stall) begin
                if (cu_flush) r_flush_pend <= 1'b1;
            end else begin
                r_flush_pend <= 1'b0;
            end
            if (bubble_clr) begin
                r_bub_cnt <= '0;
            end else if (out_ready && !w_m_valid && !cu_stall && (r_bub_cnt != '1)) begin
                r_bub_cnt <= r_bub_cnt + BUB_CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_m_valid && !cu_stall;
    assign out_data   = out_valid ? w_m_data : NOP_VAL;
    assign out_nop    = !out_valid;
    assign flush_pend = r_flush_pend;
    assign occupancy  = 2'(w_m_valid) + 2'(w_s_valid);
    assign bubble_cnt = r_bub_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Scoreboard bench for pipe_stage_buf (8-bit payload, skid on).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

    localparam int               c_DW  = 8;
    localparam logic [c_DW-1:0]  c_NOP = 8'hEE;
    localparam int               c_BW  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, out_valid, out_ready, out_nop;
    logic [c_DW-1:0] in_data, out_data;
    logic            cu_stall, cu_flush, flush_pend, bubble_clr;
    logic [1:0]      occupancy;
    logic [c_BW-1:0] bubble_cnt;

    int              total = 0;
    int              bad   = 0;
    int              n_out = 0;
    int              base;
    int              k;
    logic            acc;
    logic            pend_m = 1'b0;
    logic [c_DW-1:0] sb_q[$];

    pipe_stage_buf #(.DATA_W(c_DW), .NOP_VAL(c_NOP), .SKID_EN(1), .BUB_CNT_W(c_BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nop    (out_nop),
        .cu_stall   (cu_stall),
        .cu_flush   (cu_flush),
        .flush_pend (flush_pend),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt),
        .bubble_clr (bubble_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change just after the active (falling) edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples on the rising edge, ahead of the falling edge that acts
    always @(posedge clk) begin
        if (!reset) begin
            sb_q.delete();
            pend_m = 1'b0;
        end else begin
            if (!out_valid) check("nop_data", 32'(out_data), 32'(c_NOP));
            if (cu_stall) begin
                check("stall_out_valid", 32'(out_valid), 32'd0);
                if (cu_flush) pend_m = 1'b1;
            end else if (cu_flush || pend_m) begin
                sb_q.delete();
                pend_m = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got 0x%0h expected none", out_data);
                    end else begin
                        check("beat_data", 32'(out_data), 32'(sb_q.pop_front()));
                    end
                    n_out++;
                end
                if (in_valid && in_ready) sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cu_stall = 1'b0; cu_flush = 1'b0; bubble_clr = 1'b0;
        #1;
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'(c_NOP));
        check("rst_out_nop",    32'(out_nop),    32'd1);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_occupancy",  32'(occupancy),  32'd0);
        check("rst_bubble",     32'(bubble_cnt), 32'd0);
        check("rst_flush_pend", 32'(flush_pend), 32'd0);
        #1 reset = 1'b1;
        #1 check("in_ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Bubble counter saturation and clear
        out_ready = 1'b1;
        tick(); tick();
        check("bubble_two", 32'(bubble_cnt), 32'd2);
        tick(); tick(); tick();
        check("bubble_saturated", 32'(bubble_cnt), 32'd3);
        bubble_clr = 1'b1;
        tick();
        bubble_clr = 1'b0;
        check("bubble_clear", 32'(bubble_cnt), 32'd0);

        // Full-throughput stream 0x01..0x10
        base = n_out;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            check("stream_occupancy", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick(); tick();
        check("stream_beats", 32'(n_out - base), 32'd16);

        // Backpressure for three edges: skid fills, nothing lost
        base = n_out;
        k    = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k < 8);
            in_data   = 8'h21 + 8'(k);
            #1 acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            if (c == 3 || c == 4) begin
                check("bp_occupancy", 32'(occupancy), 32'd2);
                check("bp_in_ready",  32'(in_ready),  32'd0);
            end
        end
        in_valid = 1'b0;
        check("bp_beats", 32'(n_out - base), 32'd8);

        // Stall holds contents and reissues them unchanged
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0; cu_stall = 1'b1;
        tick(); tick();
        check("hold_occupancy", 32'(occupancy), 32'd1);
        cu_stall = 1'b0;
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_data",  32'(out_data),  32'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush under stall is deferred until the stall drops
        in_valid = 1'b1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        check("pf_occupancy_full", 32'(occupancy), 32'd2);
        cu_stall = 1'b1; cu_flush = 1'b1;
        #1;
        check("pf_in_ready",  32'(in_ready),  32'd0);
        check("pf_out_valid", 32'(out_valid), 32'd0);
        tick();
        cu_flush = 1'b0;
        check("pf_pend_set", 32'(flush_pend), 32'd1);
        tick(); tick(); tick();
        check("pf_pend_held",      32'(flush_pend), 32'd1);
        check("pf_occupancy_held", 32'(occupancy),  32'd2);
        cu_stall = 1'b0;
        tick();
        check("pf_out_valid_after", 32'(out_valid),  32'd0);
        check("pf_pend_cleared",    32'(flush_pend), 32'd0);
        check("pf_occupancy_after", 32'(occupancy),  32'd0);
        check("pf_out_data_after",  32'(out_data),   32'(c_NOP));

        // Flush beats a simultaneous accept of 0xAB
        in_valid = 1'b1; in_data = 8'h61;
        tick();
        in_data = 8'hAB; cu_flush = 1'b1; out_ready = 1'b1;
        tick();
        cu_flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_occupancy", 32'(occupancy), 32'd0);
        base = n_out;
        tick(); tick();
        check("fl_no_beats", 32'(n_out - base), 32'd0);

        // Reset mid-stream with both entries full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h51;
        tick();
        in_data = 8'h52;
        tick();
        in_valid = 1'b0;
        check("mr_occupancy_full", 32'(occupancy), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data",  32'(out_data),  32'(c_NOP));
        check("mr_occupancy", 32'(occupancy), 32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        check("mr_out_valid_after", 32'(out_valid), 32'd0);
        check("mr_in_ready_after",  32'(in_ready),  32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
